// File: rtl/voice_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : voice_pkg
//  Description : Shared definitions for the voice playback block: request
//                FSM state encoding, the default wave size and sample-rate
//                divider values for the supported system clocks.
//  Revision    : 1.0 - initial release
// ============================================================================
package voice_pkg;

    // One-hot request FSM encoding.
    typedef enum logic [2:0] {
        ST_IDLE = 3'b001,
        ST_REQ  = 3'b010,
        ST_RECV = 3'b100
    } req_state_t;

    // Words per full wave request: 16 bursts of 8 words.
    localparam int c_wave_words = 128;

    // Clock cycles per 16 kHz output sample.
    localparam int c_div_100mhz = 6250;  // 100 MHz / 16 kHz
    localparam int c_div_133mhz = 8313;  // 133 MHz / 16 kHz, rounded

endpackage : voice_pkg
`default_nettype wire

// File: rtl/sample_buf.sv
`default_nettype none
// ============================================================================
//  Module      : sample_buf
//  Description : Synchronous FIFO holding playback samples. Pointers carry
//                one extra wrap bit so full and empty are unambiguous.
//                A push while full is dropped; a pop while empty is ignored.
//  Ports       : i_clk/i_rst   clock, synchronous active-high reset
//                i_push/i_wdata write strobe and data
//                i_pop         read strobe (o_rdata is the current head)
//                o_level       registered occupancy 0..2^AW
//                o_full/o_empty status derived from o_level
//  Revision    : 1.0 - initial release
// ============================================================================
module sample_buf #(
    parameter int DATA_WIDTH = 16,
    parameter int AW         = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic                  i_pop,
    output logic [DATA_WIDTH-1:0] o_rdata,
    output logic [AW:0]           o_level,
    output logic                  o_full,
    output logic                  o_empty
);

    localparam int c_depth = 1 << AW;

    logic [DATA_WIDTH-1:0] r_mem [c_depth];
    logic [AW:0]           r_wr_ptr;
    logic [AW:0]           r_rd_ptr;
    logic [AW:0]           r_level;
    logic                  w_do_push;
    logic                  w_do_pop;

    assign o_full    = r_level[AW];          // only set when level == depth
    assign o_empty   = (r_level == '0);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_level   = r_level;
    assign o_rdata   = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule : sample_buf
`default_nettype wire

// File: rtl/voice_playback.sv
`default_nettype none
// ============================================================================
//  Module      : voice_playback
//  Description : Requests waves from the voice SDRAM FIFO, buffers the words
//                locally and replays them at a fixed sample rate, flagging
//                underruns and buffer overflow.
//  Ports       : i_clk, i_rst          clock, synchronous active-high reset
//                i_en                  playback enable
//                o_rd                  wave read request to the SDRAM FIFO
//                i_rd_data/i_rd_ef     returned word and its valid strobe
//                i_rd_done/i_rd_fail   end-of-wave / read-failed pulses
//                o_sample/o_sample_vld output sample and per-tick strobe
//                o_underrun(_cnt)      empty-tick pulse and saturating count
//                o_overflow            sticky dropped-word flag
//                o_level, o_busy       buffer occupancy, FSM not idle
//  Revision    : 1.0 - initial release
// ============================================================================
module voice_playback
    import voice_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int WAVE_WORDS = c_wave_words,
    parameter int BUF_AW     = 8,
    parameter int SAMPLE_DIV = c_div_100mhz,
    parameter int GAP_CYC    = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_en,
    output logic                  o_rd,
    input  logic [DATA_WIDTH-1:0] i_rd_data,
    input  logic                  i_rd_ef,
    input  logic                  i_rd_done,
    input  logic                  i_rd_fail,
    output logic [DATA_WIDTH-1:0] o_sample,
    output logic                  o_sample_vld,
    output logic                  o_underrun,
    output logic [15:0]           o_underrun_cnt,
    output logic                  o_overflow,
    output logic [BUF_AW:0]       o_level,
    output logic                  o_busy
);

    localparam int c_gap_w = $clog2(GAP_CYC + 1);
    // A request only starts once a whole wave is guaranteed to fit.
    localparam logic [BUF_AW:0] c_max_level = (BUF_AW+1)'((1 << BUF_AW) - WAVE_WORDS);
    localparam logic [c_gap_w-1:0] c_gap_last = c_gap_w'(GAP_CYC - 1);
    localparam logic [15:0] c_div_last = 16'(SAMPLE_DIV - 1);

    req_state_t            r_state;
    logic                  r_rd;
    logic [c_gap_w-1:0]    r_gap;
    logic [15:0]           r_div;
    logic [DATA_WIDTH-1:0] r_sample;
    logic                  r_sample_vld;
    logic                  r_underrun;
    logic [15:0]           r_underrun_cnt;
    logic                  r_overflow;

    logic                  w_push;
    logic                  w_tick;
    logic                  w_pop;
    logic [DATA_WIDTH-1:0] w_head;
    logic [BUF_AW:0]       w_level;
    logic                  w_full;
    logic                  w_empty;

    // Words are only accepted while a request is outstanding.
    assign w_push = i_rd_ef && (r_state == ST_REQ || r_state == ST_RECV);
    assign w_tick = i_en && (r_div == c_div_last);
    assign w_pop  = w_tick && !w_empty;

    sample_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .AW         (BUF_AW)
    ) u_buf (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (w_push),
        .i_wdata (i_rd_data),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_level (w_level),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Request FSM with registered read strobe and gap timer.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_rd    <= 1'b0;
            r_gap   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_gap <= '0;
                    if (i_en && (w_level <= c_max_level)) begin
                        r_state <= ST_REQ;
                        r_rd    <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (i_rd_ef) begin
                        r_state <= ST_RECV;
                        r_rd    <= 1'b0;
                        r_gap   <= '0;
                    end else if (i_rd_fail) begin
                        r_state <= ST_IDLE;
                        r_rd    <= 1'b0;
                    end
                end
                ST_RECV: begin
                    if (i_rd_done || i_rd_fail || (!i_rd_ef && r_gap == c_gap_last)) begin
                        r_state <= ST_IDLE;
                        r_gap   <= '0;
                    end else if (i_rd_ef) begin
                        r_gap <= '0;
                    end else begin
                        r_gap <= r_gap + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_rd    <= 1'b0;
                    r_gap   <= '0;
                end
            endcase
        end
    end

    // Sample divider, output register and status flags.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_div          <= '0;
            r_sample       <= '0;
            r_sample_vld   <= 1'b0;
            r_underrun     <= 1'b0;
            r_underrun_cnt <= '0;
            r_overflow     <= 1'b0;
        end else begin
            r_sample_vld <= w_tick;
            r_underrun   <= w_tick && w_empty;
            if (!i_en || w_tick) r_div <= '0;
            else                 r_div <= r_div + 1'b1;
            if (w_tick) begin
                r_sample <= w_empty ? '0 : w_head;
                if (w_empty && r_underrun_cnt != 16'hFFFF) begin
                    r_underrun_cnt <= r_underrun_cnt + 1'b1;
                end
            end
            if (w_push && w_full) r_overflow <= 1'b1;
        end
    end

    assign o_rd           = r_rd;
    assign o_busy         = (r_state != ST_IDLE);
    assign o_level        = w_level;
    assign o_sample       = r_sample;
    assign o_sample_vld   = r_sample_vld;
    assign o_underrun     = r_underrun;
    assign o_underrun_cnt = r_underrun_cnt;
    assign o_overflow     = r_overflow;

endmodule : voice_playback
`default_nettype wire
